// File: rtl/proc_ctrl_unit.sv
// Instruction-receiving control unit: free-running 4-tick sequencer plus per-tick datapath decode.
// Optional sticky undefined-opcode flag is built only when PROC_ILLEGAL_OP_EN is defined.
module proc_ctrl_unit #(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IMM_W-1:0]  din,
    output logic [3:0]        tick_FSM,
    output logic [3:0]        bus_control,
    output logic [7:0]        rin,
    output logic              a_in,
    output logic              g_in,
    output logic              alu_sub,
    output logic [DATA_W-1:0] imm_out,
    output logic              done,
    output logic              illegal_op
);

    typedef enum logic [3:0] {
        T1 = 4'b0001,
        T2 = 4'b0010,
        T3 = 4'b0100,
        T4 = 4'b1000
    } tick_e;

    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MOVI = 3'd7;

    localparam logic [3:0] BUS_IMM  = 4'd8;
    localparam logic [3:0] BUS_G    = 4'd9;
    localparam logic [3:0] BUS_NONE = 4'd15;

    tick_e            tick_q, tick_d;
    logic [IMM_W-1:0] ir_q, imm_q;

    logic [2:0] op, rx, ry;
    logic       is_alu;

    assign op     = ir_q[IMM_W-1 -: 3];
    assign rx     = ir_q[5:3];
    assign ry     = ir_q[2:0];
    assign is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);

    function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= T1;
            ir_q   <= '0;
            imm_q  <= '0;
        end else begin
            tick_q <= tick_d;
            if (tick_q == T1) ir_q  <= din;
            if (tick_q == T2) imm_q <= din;
        end
    end

    always_comb begin
        tick_d = T1;
        case (tick_q)
            T1:      tick_d = T2;
            T2:      tick_d = T3;
            T3:      tick_d = T4;
            T4:      tick_d = T1;
            default: tick_d = T1;
        endcase
    end

    // Decode: T2 may look at live din (MOVI immediate), T3 uses the captured imm_q.
    always_comb begin
        bus_control = BUS_NONE;
        rin         = '0;
        a_in        = 1'b0;
        g_in        = 1'b0;
        alu_sub     = 1'b0;
        imm_out     = '0;
        done        = 1'b0;
        case (tick_q)
            T2: begin
                if (op == OP_MOVI) begin
                    bus_control = BUS_IMM;
                    imm_out     = sext(din);
                    rin         = 8'b1 << rx;
                    done        = 1'b1;
                end else if (is_alu) begin
                    bus_control = {1'b0, rx};
                    a_in        = 1'b1;
                end
            end
            T3: begin
                if (op == OP_ADDI) begin
                    bus_control = BUS_IMM;
                    imm_out     = sext(imm_q);
                    g_in        = 1'b1;
                end else if (is_alu) begin
                    bus_control = {1'b0, ry};
                    g_in        = 1'b1;
                    alu_sub     = (op == OP_SUB);
                end
            end
            T4: begin
                if (is_alu) begin
                    bus_control = BUS_G;
                    rin         = 8'b1 << rx;
                    done        = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign tick_FSM = tick_q;

`ifdef PROC_ILLEGAL_OP_EN
    logic illegal_q;
    logic din_undef;

    assign din_undef = !(din[IMM_W-1 -: 3] inside {OP_ADD, OP_ADDI, OP_SUB, OP_MOVI});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          illegal_q <= 1'b0;
        else if (tick_q == T1 && din_undef) illegal_q <= 1'b1;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_proc_ctrl_unit.sv
// Directed bench for proc_ctrl_unit: per-tick vector table plus reset-abort sequence.
module tb_proc_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  din = '0;
    logic [3:0]  tick_FSM, bus_control;
    logic [7:0]  rin;
    logic        a_in, g_in, alu_sub, done, illegal_op;
    logic [15:0] imm_out;

    int checks = 0;
    int errors = 0;

`ifdef PROC_ILLEGAL_OP_EN
    localparam bit IL = 1'b1;
`else
    localparam bit IL = 1'b0;
`endif

    proc_ctrl_unit #(.DATA_W(16), .IMM_W(9)) dut (
        .clk(clk), .rst(rst), .din(din),
        .tick_FSM(tick_FSM), .bus_control(bus_control), .rin(rin),
        .a_in(a_in), .g_in(g_in), .alu_sub(alu_sub), .imm_out(imm_out),
        .done(done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  din;
        logic [3:0]  tick;
        logic [3:0]  bus;
        logic [7:0]  rin;
        logic        a, g, sub;
        logic [15:0] imm;
        logic        done;
        logic        il;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [8:0] d, input logic [3:0] t, input logic [3:0] b,
                                input logic [7:0] r, input logic a, input logic g, input logic s,
                                input logic [15:0] im, input logic dn, input logic il);
        vec_t v;
        v.din = d; v.tick = t; v.bus = b; v.rin = r; v.a = a; v.g = g; v.sub = s;
        v.imm = im; v.done = dn; v.il = il;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".tick"}, 32'(tick_FSM), 32'(v.tick));
        chk({tag, ".bus"},  32'(bus_control), 32'(v.bus));
        chk({tag, ".rin"},  32'(rin), 32'(v.rin));
        chk({tag, ".a_in"}, 32'(a_in), 32'(v.a));
        chk({tag, ".g_in"}, 32'(g_in), 32'(v.g));
        chk({tag, ".sub"},  32'(alu_sub), 32'(v.sub));
        chk({tag, ".imm"},  32'(imm_out), 32'(v.imm));
        chk({tag, ".done"}, 32'(done), 32'(v.done));
        chk({tag, ".ill"},  32'(illegal_op), 32'(v.il));
    endtask

    // Expected record with everything idle at a given tick.
    function automatic vec_t idle(input logic [3:0] t, input logic il);
        vec_t v;
        v.din = '0; v.tick = t; v.bus = 4'd15; v.rin = '0; v.a = 0; v.g = 0; v.sub = 0;
        v.imm = '0; v.done = 0; v.il = il;
        return v;
    endfunction

    initial begin
        //   din     tick     bus    rin        a  g  s  imm       dn il
        // MOVI r0,10
        add(9'h1C0, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h00A, 4'b0010, 4'd8,  8'h01,     0, 0, 0, 16'h000A, 1, 0);
        add(9'h000, 4'b0100, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b1000, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        // MOVI r1,-10
        add(9'h1C8, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h1F6, 4'b0010, 4'd8,  8'h02,     0, 0, 0, 16'hFFF6, 1, 0);
        add(9'h000, 4'b0100, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b1000, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        // MOVI r7,-256 (most negative immediate)
        add(9'h1F8, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h100, 4'b0010, 4'd8,  8'h80,     0, 0, 0, 16'hFF00, 1, 0);
        add(9'h000, 4'b0100, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b1000, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        // ADD r2,r3
        add(9'h053, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0010, 4'd2,  8'h00,     1, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0100, 4'd3,  8'h00,     0, 1, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b1000, 4'd9,  8'h04,     0, 0, 0, 16'h0000, 1, 0);
        // SUB r0,r1
        add(9'h0C1, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0010, 4'd0,  8'h00,     1, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0100, 4'd1,  8'h00,     0, 1, 1, 16'h0000, 0, 0);
        add(9'h000, 4'b1000, 4'd9,  8'h01,     0, 0, 0, 16'h0000, 1, 0);
        // ADDI r7,-20: immediate captured in T2, din cleared before T3
        add(9'h0B8, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h1EC, 4'b0010, 4'd7,  8'h00,     1, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0100, 4'd8,  8'h00,     0, 1, 0, 16'hFFEC, 0, 0);
        add(9'h000, 4'b1000, 4'd9,  8'h80,     0, 0, 0, 16'h0000, 1, 0);
        // ADD r6,r6 (rx == ry)
        add(9'h076, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0010, 4'd6,  8'h00,     1, 0, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b0100, 4'd6,  8'h00,     0, 1, 0, 16'h0000, 0, 0);
        add(9'h000, 4'b1000, 4'd9,  8'h40,     0, 0, 0, 16'h0000, 1, 0);
        // opcode 5: NOP frame, flag sets on T1->T2 edge when enabled
        add(9'h140, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, 0);
        add(9'h1FF, 4'b0010, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, IL);
        add(9'h000, 4'b0100, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, IL);
        add(9'h000, 4'b1000, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, IL);
        // ADDI r3,+5 after the NOP
        add(9'h098, 4'b0001, 4'd15, 8'h00,     0, 0, 0, 16'h0000, 0, IL);
        add(9'h005, 4'b0010, 4'd3,  8'h00,     1, 0, 0, 16'h0000, 0, IL);
        add(9'h000, 4'b0100, 4'd8,  8'h00,     0, 1, 0, 16'h0005, 0, IL);
        add(9'h000, 4'b1000, 4'd9,  8'h08,     0, 0, 0, 16'h0000, 1, IL);

        // Reset held for two clocks
        repeat (2) @(negedge clk);
        #2 chk_all("reset", idle(4'b0001, 1'b0));

        @(negedge clk);
        rst = 1'b1;
        foreach (vecs[i]) begin
            din = vecs[i].din;
            #2 chk_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

        // ADD r4,r5 aborted by reset in T3
        din = 9'h065;
        #2 chk("abort.t1", 32'(tick_FSM), 32'h1);
        @(negedge clk); din = 9'h000;
        #2 chk("abort.t2bus", 32'(bus_control), 32'd4);
        @(negedge clk);
        #2 chk("abort.t3g", 32'(g_in), 32'd1);
        chk("abort.t3bus", 32'(bus_control), 32'd5);
        #1 rst = 1'b0;
        #1 chk_all("abort.rst", idle(4'b0001, 1'b0));
        repeat (2) @(negedge clk);
        #2 chk_all("abort.hold", idle(4'b0001, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        din = 9'h000;
        #2 chk_all("post.t1", idle(4'b0001, 1'b0));
        @(negedge clk);
        #2 chk_all("post.t2", idle(4'b0010, IL));
        @(negedge clk);
        #2 chk_all("post.t3", idle(4'b0100, IL));
        @(negedge clk);
        #2 chk_all("post.t4", idle(4'b1000, IL));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_unit.md
Name: proc_ctrl_unit

Overview:
Instruction-receiving control unit for the simple 16-bit processor. It consumes the 9-bit `din` instruction stream, one instruction per 4-tick frame, in the format the processor testbench drives. It sequences a free-running 4-tick FSM and emits per-tick datapath controls: bus source select, register write enables, A/G latch enables, ALU add/sub, sign-extended immediate. It sits between the `din` input pin and the register file/ALU/bus mux.

Parameters:
DATA_W, 16, datapath/bus width; immediate is sign-extended to this width
IMM_W, 9, `din` width; opcode/rx/ry fields are fixed at 3 bits each

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-low (0 = reset)
din  input  IMM_W  T1: {opcode[8:6], rx[5:3], ry[2:0]}; T2: immediate for ADDI/MOVI
tick_FSM  output  4  one-hot current tick: 0001=T1, 0010=T2, 0100=T3, 1000=T4
bus_control  output  4  bus source: 0-7 = R0-R7, 8 = immediate, 9 = G, 15 = none (bus driven 0)
rin  output  8  one-hot register write enable, bit n = Rn, written at end of tick
a_in  output  1  load A from bus at end of tick
g_in  output  1  load G from ALU (A op bus) at end of tick
alu_sub  output  1  0 = A+bus, 1 = A-bus; valid when g_in=1
imm_out  output  DATA_W  sign-extended immediate, driven when bus_control=8, else 0
done  output  1  high during last active tick of a legal instruction
illegal_op  output  1  sticky undefined-opcode flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): tick_FSM=0001, IR=0 (NOP), imm_reg=0, bus_control=15, rin=0, a_in=g_in=alu_sub=done=0, imm_out=0, illegal_op=0. Reset mid-instruction aborts it immediately. No write occurs.
- Tick FSM: T1→T2→T3→T4→T1 on every posedge, free-running, independent of opcode.
- T1: all controls inactive (bus_control=15). On the T1→T2 edge, IR<=din.
- T2 controls are decoded from IR and live `din`. On the T2→T3 edge, imm_reg<=din. T3 controls use imm_reg.
- Opcodes:
  - MOVI (7): T2 bus=8, imm_out=sext(din), rin[rx]=1, done=1. T3 and T4 idle.
  - ADD (1): T2 bus=rx, a_in. T3 bus=ry, g_in, alu_sub=0. T4 bus=9, rin[rx], done.
  - SUB (3): as ADD, but alu_sub=1 in T3.
  - ADDI (2): T2 bus=rx, a_in. T3 bus=8, imm_out=sext(imm_reg), g_in, alu_sub=0. T4 bus=9, rin[rx], done.
  - 0, 4, 5, 6: NOP. Full 4 ticks, no enables, done=0.
- rx=ry is legal: the same register is read in T2 and T3.
- Sign extension: imm_out = {{(DATA_W-IMM_W){imm[8]}}, imm}. Arithmetic wraps mod 2^DATA_W (ALU responsibility; no overflow flag).
- Outputs are combinational from registered state (tick, IR, imm_reg) plus `din` in T2 only. They are glitch-free relative to posedge sampling.
- Exactly one bit of rin is asserted at most, and only in the tick listed above.

Optional Feature:
PROC_ILLEGAL_OP_EN
- Defined: illegal_op is set on the T1→T2 edge when din[8:6] ∈ {0,4,5,6}. It stays set until reset; a NOP frame still executes as above.
- Undefined: the illegal_op port exists but is tied 0, and no flag register is built.

Test Plan:
1. Hold rst=0 for 2 clocks → tick_FSM=0001, bus_control=15, rin=0, a_in=g_in=done=0, imm_out=0. Release rst → tick_FSM steps 0001,0010,0100,1000,0001.
2. MOVI r0,10: din=9'b111_000_000 in T1, 9'd10 in T2 → T2: bus_control=8, imm_out=16'd10, rin=8'b0000_0001, done=1. T3/T4: rin=0, bus_control=15.
3. MOVI r1,-10: T2 din=9'h1F6 → imm_out=16'hFFF6, rin=8'b0000_0010.
4. ADD r2,r3 (din=9'b001_010_011) → T2: bus=2, a_in=1. T3: bus=3, g_in=1, alu_sub=0. T4: bus=9, rin=8'b0000_0100, done=1.
5. SUB r0,r1 → T3 alu_sub=1, T4 rin=8'b0000_0001. ADDI r7,-20 (T2 din=9'h1EC) → T2: bus=7, a_in. T3: bus=8, imm_out=16'hFFEC, g_in. T4: bus=9, rin=8'b1000_0000.
6. Assert rst during T3 of ADD r4,r5 → tick_FSM=0001, g_in=0, rin=0 immediately; no T4 write. Opcode 5 frame → no enables for 4 ticks, done=0; illegal_op=1 only with PROC_ILLEGAL_OP_EN.
